// File: rtl/ext_pipe_pkg.sv
// rtl/ext_pipe_pkg.sv - shared mode encodings and default widths for the immediate extender
package ext_pipe_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 32;
    localparam int DEF_SHL   = 2;
    localparam int DEF_TAG_W = 5;

    localparam logic [2:0] EXT_SEXT  = 3'b000;
    localparam logic [2:0] EXT_ZEXT  = 3'b001;
    localparam logic [2:0] EXT_HIGH  = 3'b010;
    localparam logic [2:0] EXT_SSHL  = 3'b011;
    localparam logic [2:0] EXT_BSEXT = 3'b100;
    localparam logic [2:0] EXT_BZEXT = 3'b101;

endpackage

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational (imm, op) -> (ext, err) extension for all six modes
module ext_core
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHL   = DEF_SHL
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [2:0]       op,
    output logic [OUT_W-1:0] ext,
    output logic             err
);

    logic [OUT_W-1:0] sext;

    assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

    always_comb begin
        ext = '0;
        err = 1'b0;
        case (op)
            EXT_SEXT:  ext = sext;
            EXT_ZEXT:  ext = {{(OUT_W-IN_W){1'b0}}, imm};
            EXT_HIGH:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
            EXT_SSHL:  ext = sext << SHL;
            EXT_BSEXT: ext = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            EXT_BZEXT: ext = {{(OUT_W-8){1'b0}}, imm[7:0]};
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - registered immediate extender with a 2-entry result buffer and flush
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHL   = DEF_SHL,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [1:0]       count
);

    logic [OUT_W-1:0] new_ext, ext0, ext1;
    logic [TAG_W-1:0] tag0, tag1;
    logic             new_err, err0, err1;
    logic [1:0]       cnt;
    logic             push, pop;

    ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHL(SHL)) u_core (
        .imm (in_imm),
        .op  (in_op),
        .ext (new_ext),
        .err (new_err)
    );

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt;

    // Entry 0 is always the head; the stale contents of an empty slot are masked here.
    assign out_ext = out_valid ? ext0 : '0;
    assign out_tag = out_valid ? tag0 : '0;
    assign out_err = out_valid & err0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= 2'd0;
            ext0 <= '0;
            ext1 <= '0;
            tag0 <= '0;
            tag1 <= '0;
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else if (flush) begin
            cnt  <= 2'd0;
            ext0 <= '0;
            ext1 <= '0;
            tag0 <= '0;
            tag1 <= '0;
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        ext0 <= new_ext;
                        tag0 <= in_tag;
                        err0 <= new_err;
                    end else begin
                        ext1 <= new_ext;
                        tag1 <= in_tag;
                        err1 <= new_err;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ext0 <= ext1;
                    tag0 <= tag1;
                    err0 <= err1;
                    cnt  <= cnt - 2'd1;
                end
                // Only reachable at count 1, so the pushed beat becomes the new head.
                2'b11: begin
                    ext0 <= new_ext;
                    tag0 <= in_tag;
                    err0 <= new_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - randomized and directed self-checking bench for ext_pipe
module tb_ext_pipe;

    typedef struct {
        logic [31:0] ext;
        logic [4:0]  tag;
        logic        err;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_ext;
    logic [4:0]  out_tag;
    logic        out_err;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;
    ent_t q[$];

    ext_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ext   (out_ext),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic ent_t model(input logic [2:0] op, input logic [15:0] imm, input logic [4:0] tag);
        ent_t e;
        int   s;
        int   b;
        s = int'($signed(imm));
        b = int'($signed(imm[7:0]));
        e.tag = tag;
        e.err = 1'b0;
        case (op)
            3'd0: e.ext = s;
            3'd1: e.ext = 32'(imm);
            3'd2: e.ext = 32'(imm) * 32'h10000;
            3'd3: e.ext = s * 4;
            3'd4: e.ext = b;
            3'd5: e.ext = 32'(imm) & 32'hFF;
            default: begin
                e.ext = 32'd0;
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Every falling edge: DUT state must match the queue model.
    always @(negedge clk) begin
        chk("cmp_count", 32'(count), 32'(q.size()));
        chk("cmp_in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("cmp_out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("cmp_ext", out_ext, q[0].ext);
            chk("cmp_tag", 32'(out_tag), 32'(q[0].tag));
            chk("cmp_err", 32'(out_err), 32'(q[0].err));
        end else begin
            chk("cmp_ext_idle", out_ext, 32'd0);
            chk("cmp_tag_idle", 32'(out_tag), 32'd0);
            chk("cmp_err_idle", 32'(out_err), 32'd0);
        end
    end

    task automatic cyc(input logic v, input logic [2:0] op, input logic [15:0] imm,
                       input logic [4:0] tag, input logic ordy, input logic fl);
        bit p;
        bit o;
        in_valid  = v;
        in_op     = op;
        in_imm    = imm;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (!reset || fl) begin
            q.delete();
        end else begin
            p = v && (q.size() < 2);
            o = ordy && (q.size() > 0);
            if (o) void'(q.pop_front());
            if (p) q.push_back(model(op, imm, tag));
        end
        #1;
    endtask

    initial begin
        #12 reset = 1'b1;
        cyc(0, 3'd0, 16'h0, 5'd0, 1, 0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Mode table; each push also pops the previous head at count 1.
        cyc(1, 3'b000, 16'h8001, 5'd7, 1, 0);
        chk("sext", out_ext, 32'hFFFF8001);
        chk("sext_tag", 32'(out_tag), 32'd7);
        chk("sext_err", 32'(out_err), 32'd0);
        cyc(1, 3'b001, 16'h8001, 5'd8, 1, 0);
        chk("zext", out_ext, 32'h00008001);
        chk("pushpop_count", 32'(count), 32'd1);
        chk("pushpop_tag", 32'(out_tag), 32'd8);
        cyc(1, 3'b010, 16'h1234, 5'd9, 1, 0);
        chk("high", out_ext, 32'h12340000);
        cyc(1, 3'b011, 16'hFFFF, 5'd10, 1, 0);
        chk("sshl", out_ext, 32'hFFFFFFFC);
        cyc(1, 3'b100, 16'h0080, 5'd11, 1, 0);
        chk("bsext", out_ext, 32'hFFFFFF80);
        cyc(1, 3'b101, 16'hFF80, 5'd12, 1, 0);
        chk("bzext", out_ext, 32'h00000080);
        cyc(1, 3'b110, 16'hFFFF, 5'd13, 1, 0);
        chk("illegal_ext", out_ext, 32'd0);
        chk("illegal_err", 32'(out_err), 32'd1);
        cyc(0, 3'd0, 16'h0, 5'd0, 1, 0);
        chk("drain_count", 32'(count), 32'd0);

        // Stalled consumer: third beat refused, then FIFO order on release.
        cyc(1, 3'd0, 16'h0001, 5'd1, 0, 0);
        cyc(1, 3'd0, 16'h0002, 5'd2, 0, 0);
        chk("full_count", 32'(count), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cyc(1, 3'd0, 16'h0003, 5'd3, 0, 0);
        chk("refused_count", 32'(count), 32'd2);
        chk("stall_tag", 32'(out_tag), 32'd1);
        cyc(0, 3'd0, 16'h0, 5'd0, 1, 0);
        chk("order_second", 32'(out_tag), 32'd2);
        cyc(0, 3'd0, 16'h0, 5'd0, 1, 0);
        chk("order_empty", 32'(count), 32'd0);

        // Flush beats a simultaneous push.
        cyc(1, 3'd1, 16'h00AA, 5'd4, 0, 0);
        cyc(1, 3'd1, 16'h00BB, 5'd5, 0, 1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges while full.
        cyc(1, 3'd0, 16'h1111, 5'd6, 0, 0);
        cyc(1, 3'd0, 16'h2222, 5'd7, 0, 0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        q.delete();
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ext", out_ext, 32'd0);
        chk("arst_tag", 32'(out_tag), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #2 reset = 1'b1;
        cyc(0, 3'd0, 16'h0, 5'd0, 1, 0);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 2000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom()),
                5'($urandom()), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        cyc(0, 3'd0, 16'h0, 5'd0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
